// File: rtl/ifetch_queue.sv
// Fetch queue between the PC and decode: issues imem reads under a credit limit,
// buffers returned words in order with their addresses, and discards fetches on flush.
module ifetch_queue #(
    parameter int unsigned FULLW   = 32,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [FULLW-1:0] pc_addr,
    input  logic             pc_valid,
    output logic             pc_adv,
    input  logic             flush,
    output logic             imem_req,
    output logic [FULLW-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [FULLW-1:0] imem_rdata,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [FULLW-1:0] inst_data,
    output logic [FULLW-1:0] inst_addr,
    output logic             proto_err
);

    localparam int unsigned QAW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned AAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CW  = $clog2(QDEPTH + 1);
    localparam int unsigned SW  = CW + 2;

    typedef struct packed {
        logic [FULLW-1:0] addr;
        logic [FULLW-1:0] data;
    } entry_t;

    entry_t           q_mem [QDEPTH];
    logic [QAW-1:0]   q_wr;
    logic [QAW-1:0]   q_rd;
    logic [CW-1:0]    occ;
    logic [CW-1:0]    occ_nxt;

    logic [FULLW-1:0] a_mem [MAX_OUT];
    logic [AAW-1:0]   a_wr;
    logic [AAW-1:0]   a_rd;

    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    out_nxt;
    logic [CW-1:0]    drop;
    logic [CW-1:0]    drop_nxt;
    logic [SW-1:0]    in_flight;

    logic             rsp_drop;
    logic             rsp_take;
    logic             rsp_bad;
    logic             q_push;
    logic             q_pop;

    // Address FIFO depth need not be a power of two, so wrap explicitly.
    function automatic logic [AAW-1:0] a_inc(input logic [AAW-1:0] p);
        return (p == AAW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request issue: bounded by outstanding limit and by free queue credit.
    always_comb begin
        in_flight = SW'(outstanding) + SW'(drop);
        imem_req  = reset & pc_valid & ~flush
                  & (in_flight < SW'(MAX_OUT))
                  & ((in_flight + SW'(occ)) < SW'(QDEPTH));
        imem_addr = pc_addr;
        pc_adv    = imem_req & imem_gnt;
    end

    // Head of queue presented straight from storage.
    always_comb begin
        inst_valid = (occ != '0);
        inst_addr  = inst_valid ? q_mem[q_rd].addr : '0;
        inst_data  = inst_valid ? q_mem[q_rd].data : '0;
    end

    // Responses owed to flushed requests are consumed before real ones.
    always_comb begin
        rsp_drop = imem_rvalid & (drop != '0);
        rsp_take = imem_rvalid & (drop == '0) & (outstanding != '0);
        rsp_bad  = imem_rvalid & (drop == '0) & (outstanding == '0);
        q_push   = rsp_take & ~flush;
        q_pop    = inst_valid & inst_ready & ~flush;
    end

    always_comb begin
        occ_nxt  = occ;
        out_nxt  = outstanding;
        drop_nxt = drop;
        if (flush) begin
            occ_nxt  = '0;
            out_nxt  = '0;
            drop_nxt = CW'(in_flight - SW'(imem_rvalid && (in_flight != '0)));
        end else begin
            if (q_push && !q_pop) begin
                occ_nxt = occ + 1'b1;
            end else if (!q_push && q_pop) begin
                occ_nxt = occ - 1'b1;
            end
            if (pc_adv && !rsp_take) begin
                out_nxt = outstanding + 1'b1;
            end else if (!pc_adv && rsp_take) begin
                out_nxt = outstanding - 1'b1;
            end
            if (rsp_drop) begin
                drop_nxt = drop - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ         <= '0;
            outstanding <= '0;
            drop        <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            a_wr        <= '0;
            a_rd        <= '0;
            proto_err   <= 1'b0;
        end else begin
            occ         <= occ_nxt;
            outstanding <= out_nxt;
            drop        <= drop_nxt;
            if (rsp_bad) begin
                proto_err <= 1'b1;
            end
            if (flush) begin
                q_wr <= '0;
                q_rd <= '0;
                a_wr <= '0;
                a_rd <= '0;
            end else begin
                if (q_push) begin
                    q_wr <= q_wr + 1'b1;
                end
                if (q_pop) begin
                    q_rd <= q_rd + 1'b1;
                end
                if (pc_adv) begin
                    a_wr <= a_inc(a_wr);
                end
                if (rsp_take) begin
                    a_rd <= a_inc(a_rd);
                end
            end
        end
    end

    // Payload storage carries no reset; occupancy gates its visibility.
    always_ff @(posedge clk) begin
        if (q_push) begin
            q_mem[q_wr].addr <= a_mem[a_rd];
            q_mem[q_wr].data <= imem_rdata;
        end
        if (pc_adv) begin
            a_mem[a_wr] <= pc_addr;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, backpressure/reset sequences and
// randomized traffic checked against a queue-based reference model.
module tb_ifetch_queue;

    localparam int unsigned W  = 32;
    localparam int unsigned QD = 4;
    localparam int unsigned MO = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pc_addr;
    logic         pc_valid;
    logic         pc_adv;
    logic         flush;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;
    logic         inst_valid;
    logic         inst_ready;
    logic [W-1:0] inst_data;
    logic [W-1:0] inst_addr;
    logic         proto_err;

    always #5 clk = ~clk;

    ifetch_queue #(.FULLW(W), .QDEPTH(QD), .MAX_OUT(MO)) dut (
        .clk(clk), .reset(rst), .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_adv(pc_adv),
        .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data), .inst_addr(inst_addr),
        .proto_err(proto_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] d;
    } ent_t;

    // Reference model: delivered-but-unconsumed words, addresses awaiting data,
    // responses still owed to flushed requests, sticky error.
    ent_t         mq [$];
    logic [W-1:0] mo_q [$];
    int           mdrop;
    bit           mperr;

    typedef struct {
        logic         pv;
        logic [W-1:0] pc;
        logic         g;
        logic         rv;
        logic [W-1:0] rd;
        logic         rdy;
        logic         fl;
        logic         e_req;
        logic         e_adv;
        logic         e_iv;
        logic [W-1:0] e_ia;
        logic [W-1:0] e_id;
        logic         e_perr;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [W-1:0] pc, input logic g, input logic rv,
                         input logic [W-1:0] rd, input logic rdy, input logic fl);
        pc_valid    = pv;
        pc_addr     = pc;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        inst_ready  = rdy;
        flush       = fl;
    endtask

    task automatic add(input logic pv, input logic [W-1:0] pc, input logic g, input logic rv,
                       input logic [W-1:0] rd, input logic fl, input logic e_req,
                       input logic e_adv, input logic e_iv, input logic [W-1:0] e_ia,
                       input logic [W-1:0] e_id, input logic e_perr);
        vec_t v;
        v.pv = pv; v.pc = pc; v.g = g; v.rv = rv; v.rd = rd; v.rdy = 1'b1; v.fl = fl;
        v.e_req = e_req; v.e_adv = e_adv; v.e_iv = e_iv; v.e_ia = e_ia; v.e_id = e_id;
        v.e_perr = e_perr;
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        mq.delete();
        mo_q.delete();
        mdrop = 0;
        mperr = 1'b0;
    endtask

    // Compare DUT against model for the current cycle, advance model, go to next negedge.
    task automatic model_step();
        int   infl;
        logic ereq;
        bit   have;
        ent_t e;
        infl = mo_q.size() + mdrop;
        ereq = pc_valid && !flush && (infl < MO) && ((mq.size() + infl) < QD);
        chk("model imem_req", W'(imem_req), W'(ereq));
        chk("model pc_adv", W'(pc_adv), W'(ereq && imem_gnt));
        chk("model imem_addr", imem_addr, pc_addr);
        chk("model inst_valid", W'(inst_valid), W'(mq.size() != 0));
        chk("model inst_addr", inst_addr, (mq.size() != 0) ? mq[0].a : 32'h0);
        chk("model inst_data", inst_data, (mq.size() != 0) ? mq[0].d : 32'h0);
        chk("model proto_err", W'(proto_err), W'(mperr));
        have = 1'b0;
        e    = '0;
        if (imem_rvalid) begin
            if (mdrop > 0) begin
                mdrop--;
            end else if (mo_q.size() > 0) begin
                e.a  = mo_q.pop_front();
                e.d  = imem_rdata;
                have = 1'b1;
            end else begin
                mperr = 1'b1;
            end
        end
        if (flush) begin
            mdrop += mo_q.size();
            mo_q.delete();
            mq.delete();
        end else begin
            if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
            if (have) mq.push_back(e);
            if (ereq && imem_gnt) mo_q.push_back(pc_addr);
        end
        @(negedge clk);
    endtask

    logic [W-1:0] pc;
    logic         prev;
    int           grants;

    initial begin
        // Reset held while memory misbehaves: outputs stay quiet.
        rst = 1'b0;
        model_reset();
        drive(1'b1, 32'h44, 1'b1, 1'b1, 32'h99, 1'b1, 1'b0);
        #1;
        chk("rst imem_req", W'(imem_req), 32'h0);
        chk("rst pc_adv", W'(pc_adv), 32'h0);
        chk("rst inst_valid", W'(inst_valid), 32'h0);
        chk("rst inst_data", inst_data, 32'h0);
        chk("rst inst_addr", inst_addr, 32'h0);
        @(negedge clk);
        chk("rst proto_err", W'(proto_err), 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        model_step();
        chk("rst proto_err after release", W'(proto_err), 32'h0);

        // Backpressure with next-cycle memory response.
        pc = 32'h1000; prev = 1'b0; grants = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, pc, 1'b1, prev, 32'hD000_0000 + W'(i), 1'b0, 1'b0);
            #1;
            prev = pc_adv;
            if (pc_adv) begin
                grants++;
                pc += 4;
            end
            model_step();
        end
        chk("bp grants until full", W'(grants), W'(QD));
        drive(1'b1, pc, 1'b1, prev, 32'h0, 1'b1, 1'b0);
        #1;
        chk("bp req off when full", W'(imem_req), 32'h0);
        chk("bp head addr", inst_addr, 32'h1000);
        chk("bp head data", inst_data, 32'hD000_0001);
        prev = 1'b0;
        model_step();
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, pc, 1'b1, prev, 32'hE000_0000 + W'(i), 1'b0, 1'b0);
            #1;
            prev = pc_adv;
            if (pc_adv) begin
                grants++;
                pc += 4;
            end
            model_step();
        end
        chk("bp grants after one pop", W'(grants), 32'd1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'h0, 1'b0, prev, 32'hF000_0000 + W'(i), 1'b1, 1'b0);
            #1;
            prev = 1'b0;
            model_step();
        end
        chk("bp drained", W'(inst_valid), 32'h0);

        // Vector table: stream, flush with 2 outstanding, flush with rvalid, spurious rvalid.
        //  pv    pc        g     rv    rd             fl    req   adv   iv    ia        id             perr
        add(1'b1, 32'h0,   1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b1, 32'h4,   1'b1, 1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b1, 32'h8,   1'b1, 1'b1, 32'hA000_0004, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,   32'hA000_0000, 1'b0);
        add(1'b1, 32'hC,   1'b1, 1'b1, 32'hA000_0008, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4,   32'hA000_0004, 1'b0);
        add(1'b0, 32'h0,   1'b0, 1'b1, 32'hA000_000C, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8,   32'hA000_0008, 1'b0);
        add(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hC,   32'hA000_000C, 1'b0);
        add(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b1, 32'h40,  1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b1, 32'h44,  1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b1, 32'h48,  1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b1, 32'h100, 1'b1, 1'b1, 32'hBAD0,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b1, 32'h100, 1'b1, 1'b1, 32'hBAD1,     1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b0, 32'h0,   1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h1234_5678, 1'b0);
        add(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b1, 32'h80,  1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b1, 32'h84,  1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b0, 32'h0,   1'b0, 1'b1, 32'hBAD2,     1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b1, 32'h200, 1'b1, 1'b1, 32'hBAD3,     1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b0, 32'h0,   1'b0, 1'b1, 32'hC0DE,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'hC0DE,     1'b0);
        add(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b0, 32'h0,   1'b0, 1'b1, 32'hFFFF,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0);
        add(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1);
        add(1'b1, 32'h300, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b1);
        add(1'b0, 32'h0,   1'b0, 1'b1, 32'h55,       1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1);
        add(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'h55,       1'b1);
        add(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].pv, tbl[i].pc, tbl[i].g, tbl[i].rv, tbl[i].rd, tbl[i].rdy, tbl[i].fl);
            #1;
            chk($sformatf("vec%0d imem_req", i), W'(imem_req), W'(tbl[i].e_req));
            chk($sformatf("vec%0d pc_adv", i), W'(pc_adv), W'(tbl[i].e_adv));
            chk($sformatf("vec%0d inst_valid", i), W'(inst_valid), W'(tbl[i].e_iv));
            chk($sformatf("vec%0d inst_addr", i), inst_addr, tbl[i].e_ia);
            chk($sformatf("vec%0d inst_data", i), inst_data, tbl[i].e_id);
            chk($sformatf("vec%0d proto_err", i), W'(proto_err), W'(tbl[i].e_perr));
            model_step();
        end

        // Randomized traffic; memory only responds when something is owed.
        for (int i = 0; i < 3000; i++) begin
            int infl;
            logic rv;
            infl = mo_q.size() + mdrop;
            rv   = (infl > 0) && ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 9) < 7, rv, $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            #1;
            model_step();
        end

        // Asynchronous reset mid-cycle clears state immediately.
        drive(1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst imem_req", W'(imem_req), 32'h0);
        chk("async rst inst_valid", W'(inst_valid), 32'h0);
        chk("async rst proto_err", W'(proto_err), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h77, 1'b1, 1'b0);
        #1;
        model_step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("spurious proto_err", W'(proto_err), 32'h1);
        chk("spurious queue untouched", W'(inst_valid), 32'h0);
        model_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
